seq_counter_ctrl: RTL
=====================

Name: seq_counter_ctrl

Overview:
Sequencing controller for the team's irregular 3-bit code counter, which follows the code ring 000→001→011→101→111→010→000.
- Provides run, pause, single-step and load control over the counter state.
- Runs a programmable number of full ring passes, then stops.
- Flags ring wrap-around and illegal loaded codes.
- Sits between the top-level control/test logic and the code output consumed downstream.

Parameters:
LOOPS_W, 4, width of the loop-count input and internal loop counter.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  begin a run from IDLE, or resume a run from PAUSE.
stop  input  1  pause from RUN; abort to IDLE from PAUSE.
step_req  input  1  single advance while in PAUSE.
load  input  1  load load_val into the code register (IDLE/PAUSE only).
load_val  input  3  code to load.
loops  input  LOOPS_W  number of full ring passes per run; 0 = free-run.
out  output  3  current code.
busy  output  1  high in RUN or PAUSE.
wrap  output  1  one-cycle pulse on the 010→000 advance.
done  output  1  one-cycle pulse when the programmed loop count is exhausted.
err  output  1  one-cycle pulse when an illegal code (100 or 110) is loaded.
state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=000, state=IDLE, loop counter=0.
  - busy=0, wrap=0, done=0, err=0.
  - Reset asserted mid-run aborts immediately, with no done pulse.
- Next-code function:
  - 000→001, 001→011, 011→101, 101→111, 111→010, 010→000.
  - Codes 100 and 110 map to 000.
- "Advance" means out <= next(out) at the clock edge.
- If an advance takes 010→000, wrap=1 for the following cycle.
- Control priority within one cycle: stop > start > load > step_req.
- IDLE:
  - start=1: go to RUN and latch loops into the loop counter; no advance on this edge.
  - load=1 (without start): out <= load_val.
  - load_val of 100 or 110: out <= 000 instead and err pulses.
- RUN:
  - Advance every cycle unless stop=1.
  - stop=1: go to PAUSE with no advance on that edge.
  - load and step_req are ignored.
  - On a wrap advance, if loop counter ≠ 0, decrement it.
  - If the decrement reaches 0, go to DONE on the same edge (out=000).
  - loops=0 at start means free-run: the counter is never decremented and DONE is never reached.
- PAUSE:
  - step_req=1: one advance, with the same wrap/decrement/DONE rules as RUN.
  - start=1: return to RUN; the loop counter is NOT reloaded.
  - stop=1: go to IDLE; out holds.
  - load: same as in IDLE, including the illegal-code check.
  - Holding step_req high advances once per cycle.
- DONE:
  - done=1 for exactly this one cycle, then unconditional transition to IDLE.
  - out holds 000; all inputs are ignored.
- busy = (state==RUN) or (state==PAUSE).
- All outputs are registered, except busy, which is decoded from the state register.
- Latency: start sampled at edge N → RUN at N; first advance at edge N+1.
- Ring length is 6 advances. A run started at 000 with loops=L reaches DONE after 6·L advances.
- A run started from a code other than 000 counts its first wrap as a full pass.

Test Plan:
1. Hold reset=0 for 3 cycles, then release → out=000, state=00, busy=done=wrap=err=0.
2. loops=2, pulse start from out=000 →
   - out sequence 001,011,101,111,010,000 repeated twice.
   - wrap pulses twice.
   - done pulses in the cycle after the 12th advance.
   - state returns to 00.
3. loops=0, start, run 20 cycles → out cycles the ring continuously, wrap every 6 advances, done never asserts, busy=1.
4. In RUN at out=011, assert stop → state=10, out stays 011. Then:
   - Three step_req pulses → out 101,111,010.
   - start → resumes RUN from 010 without reloading the loop count.
5. In IDLE:
   - load=1, load_val=110 → out=000, err pulses.
   - load_val=101 → out=101, err=0.
   - In RUN, load=1 has no effect.
6. Same cycle start=1 and stop=1 in PAUSE → IDLE (stop wins). Assert reset=0 mid-RUN at out=111 → out=000 immediately, with no done pulse.

Source files
------------

// File: rtl/seq_counter_ctrl.sv
// Sequencing controller for the irregular 3-bit code ring 000>001>011>101>111>010>000.
// Latency: start at edge N enters RUN at N, first advance at N+1; all outputs registered except busy.
// Backpressure: none; stop pauses/aborts, priority stop > start > load > step_req.
//
// Ports:
//   clk, reset (async, active-low)
//   start/stop/step_req/load, load_val[2:0], loops[LOOPS_W-1:0]  control inputs
//   out[2:0] current code, busy (RUN|PAUSE), wrap/done/err one-cycle pulses,
//   state[1:0] IDLE=00 RUN=01 PAUSE=10 DONE=11
module seq_counter_ctrl #(
    parameter int LOOPS_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step_req,
    input  logic               load,
    input  logic [2:0]         load_val,
    input  logic [LOOPS_W-1:0] loops,
    output logic [2:0]         out,
    output logic               busy,
    output logic               wrap,
    output logic               done,
    output logic               err,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t             st;
    logic [LOOPS_W-1:0] loop_cnt;

    // Codes 100 and 110 are off-ring and collapse to 000.
    function automatic logic [2:0] next_code(input logic [2:0] c);
        logic [2:0] n;
        case (c)
            3'b000:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b101;
            3'b101:  n = 3'b111;
            3'b111:  n = 3'b010;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    function automatic logic is_illegal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b110);
    endfunction

    logic [2:0] adv_code;
    logic       adv_wrap;
    logic       adv_last;
    logic       do_adv;
    logic       do_load;

    assign adv_code = next_code(out);
    assign adv_wrap = (out == 3'b010);
    // Last pass ends when a wrap consumes the final loop count; loop_cnt==0 is free-run.
    assign adv_last = adv_wrap && (loop_cnt == LOOPS_W'(1));

    // Resolve control priority once so the FSM below only sees the winning action.
    assign do_adv  = ((st == ST_RUN) && !stop) ||
                     ((st == ST_PAUSE) && !stop && !start && !load && step_req);
    assign do_load = ((st == ST_IDLE) || (st == ST_PAUSE)) && !stop && !start && load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= ST_IDLE;
            out      <= 3'b000;
            loop_cnt <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;

            if (do_adv) begin
                out <= adv_code;
                if (adv_wrap) begin
                    wrap <= 1'b1;
                    if (loop_cnt != '0) begin
                        loop_cnt <= loop_cnt - LOOPS_W'(1);
                    end
                end
            end

            if (do_load) begin
                out <= is_illegal(load_val) ? 3'b000 : load_val;
                err <= is_illegal(load_val);
            end

            case (st)
                ST_IDLE: begin
                    if (!stop && start) begin
                        st       <= ST_RUN;
                        loop_cnt <= loops;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        st <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        st <= ST_IDLE;
                    end else if (start) begin
                        // Resume keeps the remaining loop count.
                        st <= ST_RUN;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase

            // A final-pass advance from RUN or a PAUSE step overrides the state above.
            if (do_adv && adv_last) begin
                st   <= ST_DONE;
                done <= 1'b1;
            end
        end
    end

    assign state = st;
    assign busy  = (st == ST_RUN) || (st == ST_PAUSE);

endmodule
